// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the core-to-async-RAM bus sequencer.
// MEM_BUS_CTRL_WRITE_VERIFY_EN adds the W_VERIFY read-back state.
package mem_bus_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  localparam logic RWN_READ  = 1'b1;
  localparam logic RWN_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_WAIT   = 3'd4,
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    R_DONE   = 3'd5,
    W_VERIFY = 3'd6
`else
    R_DONE   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_tristate.sv
// Isolates the bidirectional RAM data pad: drives it only while oe is set.
module bus_tristate #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] data_out,
  input  logic          oe,
  inout  wire  [DW-1:0] pad,
  output logic [DW-1:0] data_in
);

  assign pad     = oe ? data_out : {DW{1'bz}};
  assign data_in = pad;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-transaction sequencer between the core handshake and an async 8-bit RAM.
// Optional MEM_BUS_CTRL_WRITE_VERIFY_EN: read back each write and flag mismatches.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rwn,
  inout  wire  [DW-1:0] mem_data,
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
  output logic          verify_err,
`endif
  output logic          busy
);

  localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] data_in;
  logic          oe;
  logic          accept;
  logic          cnt_done;

  assign accept   = req_valid && req_ready;
  assign cnt_done = (cnt == '0);

  // Control state: async reset so the strobe and bus release happen without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_addr   <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept)
        mem_addr <= req_addr;
      if (state == R_WAIT && cnt_done)
        resp_rdata <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      wdata_q <= req_wdata;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            state_nx = W_SETUP;
          end else begin
            state_nx = R_WAIT;
            cnt_nx   = RD_LOAD;
          end
        end
      end
      W_SETUP: begin
        state_nx = W_STROBE;
        cnt_nx   = WR_LOAD;
      end
      W_STROBE: begin
        if (cnt_done) state_nx = W_HOLD;
        else          cnt_nx   = cnt - CW'(1);
      end
      W_HOLD: begin
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
        state_nx = W_VERIFY;
        cnt_nx   = RD_LOAD;
`else
        state_nx = IDLE;
`endif
      end
      R_WAIT: begin
        if (cnt_done) state_nx = R_DONE;
        else          cnt_nx   = cnt - CW'(1);
      end
      R_DONE: state_nx = IDLE;
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
      W_VERIFY: begin
        if (cnt_done) state_nx = IDLE;
        else          cnt_nx   = cnt - CW'(1);
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset releases them immediately
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    oe        = (state == W_SETUP) || (state == W_STROBE) || (state == W_HOLD);
    mem_rwn   = (state == W_STROBE) ? RWN_WRITE : RWN_READ;
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    resp_valid = (state == R_DONE) || (state == W_VERIFY && cnt_done);
    verify_err = (state == W_VERIFY) && cnt_done && (data_in != wdata_q);
`else
    resp_valid = (state == R_DONE) || (state == W_HOLD);
`endif
  end

  bus_tristate #(.DW(DW)) u_tri (
    .data_out (wdata_q),
    .oe       (oe),
    .pad      (mem_data),
    .data_in  (data_in)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: default-timing instance A and WR=2/RD=3 instance B.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: WR_CYCLES=1, RD_CYCLES=1
  logic       a_valid = 1'b0, a_we = 1'b0;
  logic [7:0] a_raddr = '0, a_wdata = '0;
  logic       a_ready, a_resp, a_rwn, a_busy;
  logic [7:0] a_rdata, a_addr;
  wire  [7:0] a_data;
  logic       a_drv = 1'b0, a_force = 1'b0;
  logic [7:0] ram_a [256];

  // Instance B: WR_CYCLES=2, RD_CYCLES=3
  logic       b_valid = 1'b0, b_we = 1'b0;
  logic [7:0] b_raddr = '0, b_wdata = '0;
  logic       b_ready, b_resp, b_rwn, b_busy;
  logic [7:0] b_rdata, b_addr;
  wire  [7:0] b_data;
  logic       b_drv = 1'b0;
  logic [7:0] ram_b [256];

`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
  logic a_verr, b_verr;
`endif

  mem_bus_ctrl #(.AW(8), .DW(8), .WR_CYCLES(1), .RD_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_raddr), .req_wdata(a_wdata), .resp_valid(a_resp), .resp_rdata(a_rdata),
    .mem_addr(a_addr), .mem_rwn(a_rwn), .mem_data(a_data),
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    .verify_err(a_verr),
`endif
    .busy(a_busy)
  );

  mem_bus_ctrl #(.AW(8), .DW(8), .WR_CYCLES(2), .RD_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_raddr), .req_wdata(b_wdata), .resp_valid(b_resp), .resp_rdata(b_rdata),
    .mem_addr(b_addr), .mem_rwn(b_rwn), .mem_data(b_data),
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    .verify_err(b_verr),
`endif
    .busy(b_busy)
  );

  // Async RAM models: latch on strobe low, drive the bus only when the bench enables it
  assign a_data = a_drv ? (a_force ? 8'h54 : ram_a[a_addr]) : 8'hzz;
  assign b_data = b_drv ? ram_b[b_addr] : 8'hzz;

  always @(posedge clk) begin
    if (!a_rwn) ram_a[a_addr] <= a_data;
    if (!b_rwn) ram_b[b_addr] <= b_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] addr, input logic [7:0] data);
    a_valid = 1'b1; a_we = 1'b1; a_raddr = addr; a_wdata = data;
    check("wr_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("wsetup_busy", a_busy, 1);
    check("wsetup_oe", dut_a.u_tri.oe, 1);
    check("wsetup_rwn", a_rwn, 1);
    check("wsetup_addr", a_addr, addr);
    check("wsetup_data", a_data, data);
    check("wsetup_resp", a_resp, 0);
    tick();
    check("wstrobe_rwn", a_rwn, 0);
    check("wstrobe_addr", a_addr, addr);
    check("wstrobe_data", a_data, data);
    check("wstrobe_resp", a_resp, 0);
    tick();
    check("whold_rwn", a_rwn, 1);
    check("whold_data", a_data, data);
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    check("whold_resp", a_resp, 0);
    tick();
    a_drv = 1'b1;
    #1;
    check("wver_oe", dut_a.u_tri.oe, 0);
    check("wver_resp", a_resp, 1);
    check("wver_err", a_verr, 0);
    a_drv = 1'b0;
`else
    check("whold_resp", a_resp, 1);
`endif
    tick();
    check("widle_resp", a_resp, 0);
    check("widle_ready", a_ready, 1);
    check("widle_oe", dut_a.u_tri.oe, 0);
    check("widle_addr", a_addr, addr);
  endtask

  task automatic read_a(input logic [7:0] addr, input logic [7:0] exp);
    a_valid = 1'b1; a_we = 1'b0; a_raddr = addr;
    check("rd_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("rwait_oe", dut_a.u_tri.oe, 0);
    check("rwait_rwn", a_rwn, 1);
    check("rwait_addr", a_addr, addr);
    check("rwait_resp", a_resp, 0);
    a_drv = 1'b1;
    tick();
    check("rdone_resp", a_resp, 1);
    check("rdone_rdata", a_rdata, exp);
    a_drv = 1'b0;
    tick();
    check("ridle_resp", a_resp, 0);
    check("ridle_rdata", a_rdata, exp);
    check("ridle_ready", a_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 8'h00;
      ram_b[i] = 8'h00;
    end
    rst = 1'b1;
    tick();
    tick();
    check("rst_rwn", a_rwn, 1);
    check("rst_oe", dut_a.u_tri.oe, 0);
    check("rst_ready", a_ready, 1);
    check("rst_resp", a_resp, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_addr", a_addr, 0);
    check("rst_busy", a_busy, 0);
    rst = 1'b0;
    tick();

    write_a(8'hFF, 8'h06);
    check("ram_ff", ram_a[8'hFF], 8'h06);
    write_a(8'hFE, 8'h08);
    write_a(8'hFD, 8'h0A);
    check("ram_fe", ram_a[8'hFE], 8'h08);
    check("ram_fd", ram_a[8'hFD], 8'h0A);
    read_a(8'hFE, 8'h08);
    read_a(8'hFD, 8'h0A);

    // Reset asserted mid-strobe must release the bus with no clock edge
    a_valid = 1'b1; a_we = 1'b1; a_raddr = 8'h40; a_wdata = 8'h33;
    tick();
    a_valid = 1'b0;
    tick();
    check("mid_strobe_rwn", a_rwn, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rwn", a_rwn, 1);
    check("mid_rst_oe", dut_a.u_tri.oe, 0);
    check("mid_rst_resp", a_resp, 0);
    check("mid_rst_ready", a_ready, 1);
    check("mid_rst_rdata", a_rdata, 0);
    check("mid_rst_addr", a_addr, 0);
    tick();
    check("mid_rst_resp2", a_resp, 0);
    rst = 1'b0;
    tick();
    check("ram_40_untouched", ram_a[8'h40], 8'h00);
    write_a(8'h40, 8'h5A);
    check("ram_40", ram_a[8'h40], 8'h5A);

`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    a_valid = 1'b1; a_we = 1'b1; a_raddr = 8'h10; a_wdata = 8'h55;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    check("vf_hold_resp", a_resp, 0);
    tick();
    a_force = 1'b1; a_drv = 1'b1;
    #1;
    check("vf_resp", a_resp, 1);
    check("vf_err", a_verr, 1);
    a_drv = 1'b0; a_force = 1'b0;
    tick();
    check("vf_idle_resp", a_resp, 0);
    check("vf_idle_err", a_verr, 0);
    write_a(8'h10, 8'h55);
`endif

    // Instance B: write 0x0A to 0xFD with a two-cycle strobe
    b_valid = 1'b1; b_we = 1'b1; b_raddr = 8'hFD; b_wdata = 8'h0A;
    tick();
    b_valid = 1'b0;
    check("b_wsetup_rwn", b_rwn, 1);
    tick();
    check("b_wstrobe1_rwn", b_rwn, 0);
    tick();
    check("b_wstrobe2_rwn", b_rwn, 0);
    check("b_wstrobe2_resp", b_resp, 0);
    tick();
    check("b_whold_rwn", b_rwn, 1);
`ifdef MEM_BUS_CTRL_WRITE_VERIFY_EN
    check("b_whold_resp", b_resp, 0);
    tick();
    b_drv = 1'b1;
    tick();
    tick();
    check("b_wver_resp", b_resp, 1);
    check("b_wver_err", b_verr, 0);
    b_drv = 1'b0;
`else
    check("b_whold_resp", b_resp, 1);
`endif
    tick();
    check("b_widle_resp", b_resp, 0);
    check("b_ram_fd", ram_b[8'hFD], 8'h0A);

    // Read 0xFD with req_valid held high; the changed request must be ignored while busy
    b_valid = 1'b1; b_we = 1'b0; b_raddr = 8'hFD;
    tick();
    b_we = 1'b1; b_raddr = 8'h11; b_wdata = 8'hEE;
    check("b_rwait1_oe", dut_b.u_tri.oe, 0);
    b_drv = 1'b1;
    check("b_rwait1_ready", b_ready, 0);
    tick();
    check("b_rwait2_resp", b_resp, 0);
    check("b_rwait2_busy", b_busy, 1);
    check("b_rwait2_rwn", b_rwn, 1);
    tick();
    check("b_rwait3_resp", b_resp, 0);
    check("b_rwait3_addr", b_addr, 8'hFD);
    tick();
    check("b_rdone_resp", b_resp, 1);
    check("b_rdone_rdata", b_rdata, 8'h0A);
    check("b_rdone_addr", b_addr, 8'hFD);
    b_drv = 1'b0;
    tick();
    check("b_ridle_ready", b_ready, 1);
    check("b_ridle_resp", b_resp, 0);
    b_valid = 1'b0;
    tick();
    check("b_idle_busy", b_busy, 0);
    check("b_ram_11_untouched", ram_b[8'h11], 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequencer between the processor core and the 8-bit asynchronous RAM.
- Takes single read or write requests over a valid/ready handshake.
- Drives the RAM's address and active-low write strobe (`rwn`: 1 = read, 0 = write), and owns the tri-state enable of the shared bidirectional data bus.
- Returns read data, or write completion, to the core on a one-cycle response pulse.

Parameters:
- AW, 8, address width
- DW, 8, data width
- WR_CYCLES, 1, clocks `mem_rwn` is held low per write (≥1)
- RD_CYCLES, 1, clocks address is held before read data is sampled (≥1)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  target address
- req_wdata  in  DW  write data
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_rdata  out  DW  read data, valid with resp_valid on reads; holds last read value
- mem_addr  out  AW  RAM address
- mem_rwn  out  1  RAM read/write-not (1 = read)
- mem_data  inout  DW  shared RAM data bus; driven only when internal oe = 1, else Z
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, mem_rwn = 1, oe = 0 (bus Z), mem_addr = 0
  - resp_valid = 0, resp_rdata = 0, counter = 0
  - Reset mid-write must raise mem_rwn and release the bus in the same instant; no partial response is issued.
- Accept: at a rising edge with req_valid & req_ready. Capture req_we, req_addr and req_wdata into internal registers. Request inputs are ignored at all other times.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_WAIT, R_DONE.
- Write path (accept at edge 0):
  - W_SETUP, 1 cycle: mem_addr = captured address, oe = 1, mem_data = wdata, mem_rwn = 1.
  - W_STROBE, WR_CYCLES cycles: mem_rwn = 0; address and data stable.
  - W_HOLD, 1 cycle: mem_rwn = 1, data still driven, resp_valid = 1.
  - Then IDLE. Total latency from accept to resp_valid = WR_CYCLES + 2 cycles.
- Read path:
  - R_WAIT, RD_CYCLES cycles: mem_addr driven, mem_rwn = 1, oe = 0. mem_data is sampled into resp_rdata at the clock edge that ends the final R_WAIT cycle.
  - R_DONE, 1 cycle: resp_valid = 1 with resp_rdata valid.
  - Then IDLE. Latency = RD_CYCLES + 1 cycles.
- Bus rules:
  - oe = 1 only in W_SETUP, W_STROBE and W_HOLD.
  - mem_rwn = 0 only in W_STROBE.
  - mem_rwn never falls while oe = 0, and oe never falls while mem_rwn = 0.
  - IDLE always separates transactions, so a read following a write always sees ≥1 cycle of bus turnaround.
- mem_addr holds its last value in IDLE; it is not cleared.
- Counter: cnt loads WR_CYCLES−1 or RD_CYCLES−1 on state entry and decrements to 0. Exit occurs when cnt == 0; no wrap.
- Back-to-back: req_ready rises in the IDLE cycle following W_HOLD or R_DONE. Maximum throughput is one transaction per (latency + 1) cycles.
- X on mem_data during a read is passed through to resp_rdata unfiltered.

Optional Feature:
- Macro: MEM_BUS_CTRL_WRITE_VERIFY_EN
- Defined:
  - After W_STROBE the FSM goes to W_HOLD, then a read-back state W_VERIFY of RD_CYCLES cycles (oe = 0, mem_rwn = 1).
  - The sampled data is compared with wdata.
  - resp_valid is issued at the end of verify, together with an extra output port verify_err (1 = mismatch, reset 0, valid with resp_valid).
  - Write latency becomes WR_CYCLES + RD_CYCLES + 2.
- Undefined: no W_VERIFY state and no verify_err port; write path exactly as above.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum typedef
  - localparams for the default widths
  - the RWN_READ/RWN_WRITE constants
- Sub-module bus_tristate (DW-wide: data_out, oe, inout pad, data_in) isolates the inout handling. The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: rst pulse mid-sim → mem_rwn = 1, mem_data = Z, req_ready = 1, resp_valid = 0, resp_rdata = 0.
- Write 0x06 to 0xFF (WR_CYCLES = 1) → mem_rwn low exactly 1 cycle with addr 0xFF and data 0x06; resp_valid pulses 3 cycles after accept; RAM[0xFF] = 0x06.
- Write 0x08 to 0xFE, then write 0x0A to 0xFD, then read 0xFE → resp_rdata = 0x08 at resp_valid 2 cycles after the read accept; bus Z during R_WAIT.
- RD_CYCLES = 3, WR_CYCLES = 2: read 0xFD after writing 0x0A → resp_valid 4 cycles after accept, resp_rdata = 0x0A; req_valid held high is not re-accepted while busy = 1.
- Assert rst during W_STROBE → mem_rwn returns to 1 and bus goes Z without waiting for a clock; no resp_valid; the next write after reset completes normally.
- With MEM_BUS_CTRL_WRITE_VERIFY_EN: write 0x55 to 0x10 with the RAM forced to return 0x54 → verify_err = 1 with resp_valid; normal RAM → verify_err = 0.
